// File: rtl/dm_cache_pkg.sv
// Shared widths, controller state encoding and address-field helpers for the
// direct-mapped cache controller.
package dm_cache_pkg;

   localparam int ADDR_W = 10;
   localparam int WORD_W = 10;
   localparam int LINE_W = 2 * WORD_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_MEM_REQ,
      ST_MEM_WAIT,
      ST_RESP
   } state_t;

   function automatic logic addr_offset(input logic [ADDR_W-1:0] addr);
      return addr[0];
   endfunction

   // Index and tag come back right-aligned; callers truncate to their field width.
   function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                    input int index_w);
      return (addr >> 1) & ((ADDR_W'(1) << index_w) - ADDR_W'(1));
   endfunction

   function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                  input int index_w);
      return addr >> (index_w + 1);
   endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage for dm_cache_ctrl: combinational read, synchronous
// write with per-word enables and a line-fill mode that also installs the tag.
module dm_cache_array
   import dm_cache_pkg::*;
#(
   parameter int LINES = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [$clog2(LINES)-1:0]              i_idx,
   input  logic [1:0]                            i_word_we,
   input  logic                                  i_fill,
   input  logic [ADDR_W-2-$clog2(LINES):0]       i_wr_tag,
   input  logic [LINE_W-1:0]                     i_wr_line,
   output logic                                  o_valid,
   output logic [ADDR_W-2-$clog2(LINES):0]       o_tag,
   output logic [LINE_W-1:0]                     o_line
);

   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = ADDR_W - 1 - INDEX_W;

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [LINE_W-1:0] r_data [LINES];

   assign o_valid = r_valid[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_line  = r_data[i_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (i_fill) begin
         r_valid[i_idx] <= 1'b1;
      end
   end

   // NOTE: tag and data storage carry no reset; a line is only trusted once
   // its valid bit is set, so these stay plain RAM without a reset network.
   always_ff @(posedge clk) begin
      if (i_fill) begin
         r_tag[i_idx] <= i_wr_tag;
      end
      if (i_word_we[0]) begin
         r_data[i_idx][WORD_W-1:0] <= i_wr_line[WORD_W-1:0];
      end
      if (i_word_we[1]) begin
         r_data[i_idx][LINE_W-1:WORD_W] <= i_wr_line[LINE_W-1:WORD_W];
      end
   end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of
// the 1024x10 RAM. Define DM_CACHE_STATS_EN to add hit/miss counters.
module dm_cache_ctrl
   import dm_cache_pkg::*;
#(
   parameter int LINES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [WORD_W-1:0]   cpu_wdata,
   output logic                cpu_ready,
   output logic                cpu_valid,
   output logic [WORD_W-1:0]   cpu_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   inout  wire  [LINE_W-1:0]   mem_data,
`ifdef DM_CACHE_STATS_EN
   output logic [15:0]         hit_count,
   output logic [15:0]         miss_count,
`endif
   input  logic                mem_ready
);

   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = ADDR_W - 1 - INDEX_W;

   state_t            r_state;
   logic              r_we;
   logic              r_seen_low;
   logic              r_cpu_ready;
   logic              r_cpu_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic [WORD_W-1:0] r_cpu_rdata;

   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic [TAG_W-1:0]   w_line_tag;
   logic               w_off;
   logic               w_line_valid;
   logic               w_hit;
   logic               w_mem_done;
   logic               w_fill;
   logic [1:0]         w_word_we;
   logic [LINE_W-1:0]  w_line;
   logic [LINE_W-1:0]  w_wr_line;

   assign w_idx      = INDEX_W'(addr_index(r_addr, INDEX_W));
   assign w_tag      = TAG_W'(addr_tag(r_addr, INDEX_W));
   assign w_off      = addr_offset(r_addr);
   assign w_hit      = w_line_valid && (w_line_tag == w_tag);
   assign w_mem_done = (r_state == ST_MEM_WAIT) && mem_ready && r_seen_low;

   // mem_req tracks mem_ready so a transaction still in flight from before a
   // reset is never overrun.
   assign mem_req   = (r_state == ST_MEM_REQ) && mem_ready;
   assign mem_we    = mem_req && r_we;
   assign mem_addr  = r_addr;
   assign mem_data  = mem_we ? {r_wdata, r_wdata} : 'z;
   assign cpu_ready = r_cpu_ready;
   assign cpu_valid = r_cpu_valid;
   assign cpu_rdata = r_cpu_rdata;

   // NOTE: every signal gets a default before the if-chain so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      w_word_we = 2'b00;
      w_fill    = 1'b0;
      w_wr_line = {r_wdata, r_wdata};
      if (r_state == ST_LOOKUP && r_we && w_hit) begin
         w_word_we = w_off ? 2'b10 : 2'b01;
      end else if (w_mem_done && !r_we) begin
         w_word_we = 2'b11;
         w_fill    = 1'b1;
         w_wr_line = mem_data;
      end
   end

   dm_cache_array #(.LINES(LINES)) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_idx     (w_idx),
      .i_word_we (w_word_we),
      .i_fill    (w_fill),
      .i_wr_tag  (w_tag),
      .i_wr_line (w_wr_line),
      .o_valid   (w_line_valid),
      .o_tag     (w_line_tag),
      .o_line    (w_line)
   );

   // NOTE: state and outputs use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_seen_low  <= 1'b0;
         r_cpu_ready <= 1'b1;
         r_cpu_valid <= 1'b0;
         r_cpu_rdata <= '0;
      end else begin
         r_cpu_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cpu_req) begin
                  r_we        <= cpu_we;
                  r_addr      <= cpu_addr;
                  r_wdata     <= cpu_wdata;
                  r_cpu_ready <= 1'b0;
                  r_state     <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (!r_we && w_hit) begin
                  r_cpu_rdata <= w_off ? w_line[LINE_W-1:WORD_W] : w_line[WORD_W-1:0];
                  r_cpu_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_state <= ST_MEM_REQ;
               end
            end
            ST_MEM_REQ: begin
               if (mem_ready) begin
                  r_seen_low <= 1'b0;
                  r_state    <= ST_MEM_WAIT;
               end
            end
            ST_MEM_WAIT: begin
               if (!mem_ready) begin
                  r_seen_low <= 1'b1;
               end
               if (w_mem_done) begin
                  if (!r_we) begin
                     r_cpu_rdata <= w_off ? mem_data[LINE_W-1:WORD_W] : mem_data[WORD_W-1:0];
                  end
                  r_cpu_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_cpu_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef DM_CACHE_STATS_EN
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (r_state == ST_LOOKUP) begin
         if (w_hit) begin
            if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
         end else begin
            if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: randomized traffic against an abstract
// cache/RAM model plus a responder modelling the backing RAM timing.
module tb_dm_cache_ctrl;
   import dm_cache_pkg::*;

   localparam int LINES = 16;
   localparam int CLK_P = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we;
   logic [9:0]  cpu_addr, cpu_wdata;
   logic        cpu_ready, cpu_valid;
   logic [9:0]  cpu_rdata;
   logic        mem_req, mem_we;
   logic [9:0]  mem_addr;
   wire  [19:0] mem_data;
   logic        mem_ready;
`ifdef DM_CACHE_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   logic        m_drv;
   logic [19:0] m_rdata;
   assign mem_data = m_drv ? m_rdata : 'z;

   always #(CLK_P/2) clk = ~clk;

   dm_cache_ctrl #(.LINES(LINES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_valid (cpu_valid),
      .cpu_rdata (cpu_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
`ifdef DM_CACHE_STATS_EN
      .hit_count (hit_count),
      .miss_count(miss_count),
`endif
      .mem_ready (mem_ready)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: what the CPU should see, independent of cache internals.
   logic [9:0] ref_ram [1024];
   logic [9:0] mem_ram [1024];
   int         ref_block [LINES];
   int         ref_hits = 0;
   int         ref_misses = 0;

   typedef struct {
      logic       is_wr;
      logic [9:0] addr;
      logic [9:0] wdata;
      logic [9:0] rdata;
      logic       uses_mem;
      int         lat;
   } exp_t;
   exp_t exp_q[$];

   // Backing RAM: ready drops after a request, returns 3 cycles after it,
   // write commits at the end of the first idle cycle.
   logic       m_busy = 1'b0;
   int         m_cnt  = 0;
   logic       m_wr   = 1'b0;
   logic [9:0] m_addr = '0;
   logic [9:0] m_wdata = '0;

   initial begin
      logic        n_ready, n_drv;
      logic [19:0] n_rdata;
      mem_ready = 1'b1;
      m_drv     = 1'b0;
      m_rdata   = '0;
      forever begin
         @(negedge clk);
         n_ready = mem_ready;
         n_drv   = m_drv;
         n_rdata = m_rdata;
         if (m_busy) begin
            if (!mem_ready) begin
               m_cnt--;
               if (m_cnt == 0) n_ready = 1'b1;
            end else begin
               if (m_wr) mem_ram[m_addr] = m_wdata;
               m_busy = 1'b0;
               n_drv  = 1'b0;
            end
         end
         if (mem_req) begin
            m_busy  = 1'b1;
            m_cnt   = 2;
            m_wr    = mem_we;
            m_addr  = mem_addr;
            m_wdata = mem_addr[0] ? mem_data[19:10] : mem_data[9:0];
            n_ready = 1'b0;
            if (!mem_we) begin
               n_drv   = 1'b1;
               n_rdata = {mem_ram[{mem_addr[9:1], 1'b1}], mem_ram[{mem_addr[9:1], 1'b0}]};
            end
         end
         @(posedge clk);
         #1;
         mem_ready = n_ready;
         m_drv     = n_drv;
         m_rdata   = n_rdata;
      end
   end

   // Monitor: pops the scoreboard on every completion pulse.
   initial begin
      int         cyc, acc_cyc, req_cyc, nreq;
      logic       want_ready, rq_we;
      logic [9:0] rq_addr;
      logic [19:0] rq_data;
      exp_t       e;
      cyc = 0; acc_cyc = 0; req_cyc = 0; nreq = 0;
      want_ready = 1'b0; rq_we = 1'b0; rq_addr = '0; rq_data = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            want_ready = 1'b0;
            continue;
         end
         if (want_ready) begin
            check("ready_after_valid", cpu_ready, 1);
            want_ready = 1'b0;
         end
         if (cpu_req && cpu_ready) begin
            acc_cyc = cyc;
            nreq    = 0;
         end
         if (mem_req) begin
            check("mem_req_needs_ready", mem_ready, 1);
            nreq++;
            req_cyc = cyc;
            rq_we   = mem_we;
            rq_addr = mem_addr;
            rq_data = mem_data;
         end
         if (cpu_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_valid: got cpu_valid with empty scoreboard (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("ready_low_in_resp", cpu_ready, 0);
               if (!e.is_wr) check($sformatf("rdata@%0d", e.addr), cpu_rdata, e.rdata);
               check($sformatf("mem_req_count@%0d", e.addr), nreq, e.uses_mem);
               if (e.uses_mem && nreq > 0) begin
                  check("mem_addr", rq_addr, e.addr);
                  check("mem_we", rq_we, e.is_wr);
                  if (e.is_wr) check("mem_wdata", rq_data, {e.wdata, e.wdata});
                  check("mem_req_latency", req_cyc - acc_cyc, 2);
               end
               check($sformatf("valid_latency@%0d", e.addr), cyc - acc_cyc, e.lat);
               want_ready = 1'b1;
            end
         end
      end
   end

   // Issue one request from posedge+1; junk requests while busy must be ignored.
   task automatic issue(input logic wr, input logic [9:0] addr, input logic [9:0] wdata,
                        input logic track);
      exp_t e;
      int   blk, idx, guard;
      guard = 0;
      while (!cpu_ready && guard < 64) begin
         cpu_req   = 1'($urandom);
         cpu_we    = 1'($urandom);
         cpu_addr  = 10'($urandom);
         cpu_wdata = 10'($urandom);
         @(posedge clk);
         #1;
         guard++;
      end
      if (!cpu_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL ready_timeout: cpu_ready still 0 after %0d cycles", guard);
         cpu_req = 1'b0;
         return;
      end
      if (track) begin
         blk = int'(addr) / 2;
         idx = blk % LINES;
         e.is_wr    = wr;
         e.addr     = addr;
         e.wdata    = wdata;
         e.rdata    = ref_ram[addr];
         e.uses_mem = wr || (ref_block[idx] != blk);
         e.lat      = e.uses_mem ? 6 : 2;
         if (ref_block[idx] == blk) ref_hits++;
         else                       ref_misses++;
         if (wr) ref_ram[addr]  = wdata;
         else    ref_block[idx] = blk;
         exp_q.push_back(e);
      end
      cpu_req   = 1'b1;
      cpu_we    = wr;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      @(posedge clk);
      #1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || !cpu_ready) && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (exp_q.size() != 0 || !cpu_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
      end
   endtask

   initial begin
      #(CLK_P * 60000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] v;
      for (int i = 0; i < 1024; i++) begin
         v = 10'($urandom);
         ref_ram[i] = v;
         mem_ram[i] = v;
      end
      ref_ram[10] = 10'd5;  mem_ram[10] = 10'd5;
      ref_ram[11] = 10'd10; mem_ram[11] = 10'd10;
      for (int i = 0; i < LINES; i++) ref_block[i] = -1;

      rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_cpu_ready", cpu_ready, 1);
      check("rst_cpu_valid", cpu_valid, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
`ifdef DM_CACHE_STATS_EN
      check("rst_hit_count", hit_count, 0);
      check("rst_miss_count", miss_count, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(1'b0, 10'd10,  10'd0,  1'b1);   // miss, fills line 5
      issue(1'b0, 10'd11,  10'd0,  1'b1);   // hit in the same line
      issue(1'b1, 10'd11,  10'd42, 1'b1);   // write hit, written through
      issue(1'b0, 10'd11,  10'd0,  1'b1);   // hit sees 42
      issue(1'b0, 10'd42,  10'd0,  1'b1);   // same index, evicts
      issue(1'b0, 10'd10,  10'd0,  1'b1);   // misses again
      issue(1'b1, 10'd100, 10'd7,  1'b1);   // write miss, no allocate
      issue(1'b0, 10'd100, 10'd0,  1'b1);   // read miss returns committed 7
      drain();

      // Abort a read miss in its cycle 3, then restart immediately.
      issue(1'b0, 10'd200, 10'd0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #1 rst_n = 1'b0;
      #1;
      check("abort_cpu_ready", cpu_ready, 1);
      check("abort_cpu_valid", cpu_valid, 0);
      check("abort_cpu_rdata", cpu_rdata, 0);
      check("abort_mem_req", mem_req, 0);
      check("abort_mem_we", mem_we, 0);
      check("abort_mem_addr", mem_addr, 0);
`ifdef DM_CACHE_STATS_EN
      check("abort_hit_count", hit_count, 0);
      check("abort_miss_count", miss_count, 0);
`endif
      for (int i = 0; i < LINES; i++) ref_block[i] = -1;
      ref_hits   = 0;
      ref_misses = 0;
      #1 rst_n = 1'b1;
      issue(1'b0, 10'd10, 10'd0, 1'b1);     // valid bits cleared: must miss
      issue(1'b0, 10'd11, 10'd0, 1'b1);
      drain();
`ifdef DM_CACHE_STATS_EN
      check("post_abort_miss_count", miss_count, 16'(ref_misses));
      check("post_abort_hit_count", hit_count, 16'(ref_hits));
`endif

      for (int n = 0; n < 150; n++) begin
         issue(($urandom_range(0, 2) == 0), 10'($urandom_range(0, 79)), 10'($urandom), 1'b1);
      end
      drain();
`ifdef DM_CACHE_STATS_EN
      check("final_hit_count", hit_count, 16'(ref_hits));
      check("final_miss_count", miss_count, 16'(ref_misses));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
